// File: rtl/fifo_serial_tx.sv
// Purpose : pops words from a first-word-fall-through FIFO and sends each as a
//           framed serial stream: start(0), WIDTH data bits LSB first,
//           even parity, stop(1).
// Latency : pop in cycle N drives the start bit on tx in cycle N+1.
//           A frame lasts (WIDTH+3)*CLKS_PER_BIT cycles.
// Backpressure: a new word is popped only when en=1, the FIFO is non-empty,
//           and the line is idle or in the last cycle of a stop bit.
//           Frames may therefore run back to back with no idle gap.
//           Dropping en never truncates a frame that has already started.
// Ports   : clk/rst (sync, active-high); en gates frame starts;
//           fifo_empty/fifo_data are the FIFO head; fifo_deq is the
//           combinational pop strobe. tx is the serial line (idles high).
//           busy is high while a frame is on the line. frame_done pulses on
//           the last cycle of each stop bit.
module fifo_serial_tx #(
   parameter int WIDTH        = 32,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             fifo_deq,
   output logic             tx,
   output logic             busy,
   output logic             frame_done
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t           state, state_n;
   logic [BW-1:0]    baud, baud_n;
   logic [IW-1:0]    idx, idx_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic             par, par_n;
   logic             tx_n, busy_n, done_n;
   logic             bit_end;
   logic             pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         baud       <= '0;
         idx        <= '0;
         shreg      <= '0;
         par        <= 1'b0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         baud       <= baud_n;
         idx        <= idx_n;
         shreg      <= shreg_n;
         par        <= par_n;
         tx         <= tx_n;
         busy       <= busy_n;
         frame_done <= done_n;
      end
   end

   always_comb begin
      bit_end = (baud == BAUD_LAST);
      // The last stop cycle doubles as a pop slot so frames can abut.
      pop = !rst && en && !fifo_empty &&
            ((state == IDLE) || ((state == STOP) && bit_end));
      fifo_deq = pop;

      state_n = state;
      baud_n  = baud;
      idx_n   = idx;
      shreg_n = shreg;
      par_n   = par;

      if (state != IDLE) begin
         baud_n = bit_end ? '0 : baud + BW'(1);
      end

      case (state)
         IDLE: begin
            if (pop) begin
               state_n = START;
               baud_n  = '0;
               shreg_n = fifo_data;
               par_n   = ^fifo_data;
            end
         end
         START: begin
            if (bit_end) begin
               state_n = DATA;
               idx_n   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               shreg_n = shreg >> 1;
               if (idx == IDX_LAST) begin
                  state_n = PARITY;
                  idx_n   = '0;
               end else begin
                  idx_n = idx + IW'(1);
               end
            end
         end
         PARITY: begin
            if (bit_end) state_n = STOP;
         end
         STOP: begin
            if (bit_end) begin
               if (pop) begin
                  state_n = START;
                  shreg_n = fifo_data;
                  par_n   = ^fifo_data;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: begin
            state_n = IDLE;
            baud_n  = '0;
            idx_n   = '0;
         end
      endcase

      // Outputs are registered from the next-state view so the line level
      // changes on the same edge as the state it belongs to.
      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shreg_n[0];
         PARITY:  tx_n = par_n;
         default: tx_n = 1'b1;
      endcase
      busy_n = (state_n != IDLE);
      done_n = (state_n == STOP) && (baud_n == BAUD_LAST);
   end

endmodule

// File: tb/tb_fifo_serial_tx.sv
module tb_fifo_serial_tx;

   localparam int WA = 8;
   localparam int CA = 4;
   localparam int WB = 32;
   localparam int CB = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          en_a, fe_a, deq_a, tx_a, busy_a, done_a;
   logic [WA-1:0] fd_a;
   logic          en_b, fe_b, deq_b, tx_b, busy_b, done_b;
   logic [WB-1:0] fd_b;

   fifo_serial_tx #(.WIDTH(WA), .CLKS_PER_BIT(CA)) dut_a (
      .clk(clk), .rst(rst), .en(en_a), .fifo_empty(fe_a), .fifo_data(fd_a),
      .fifo_deq(deq_a), .tx(tx_a), .busy(busy_a), .frame_done(done_a));

   fifo_serial_tx #(.WIDTH(WB), .CLKS_PER_BIT(CB)) dut_b (
      .clk(clk), .rst(rst), .en(en_b), .fifo_empty(fe_b), .fifo_data(fd_b),
      .fifo_deq(deq_b), .tx(tx_b), .busy(busy_b), .frame_done(done_b));

   always #5 clk = ~clk;

   typedef struct packed {
      logic tx;
      logic fd;
   } exp_t;

   exp_t          qa[$];
   exp_t          qb[$];
   logic [WA-1:0] fa[$];
   logic [WB-1:0] fb[$];

   int checks = 0, failures = 0;
   int pops_a = 0, pops_b = 0, cyc = 0;
   int busy_cnt_a = 0, busy_cnt_b = 0, last_pop_a = 0, last_pop_b = 0;
   bit mon_en = 0, sb_off_a = 0;
   bit pend_a = 0, pend_b = 0, prev_deq_a = 0, prev_deq_b = 0, rst_prev = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic refresh_a();
      fe_a = (fa.size() == 0);
      fd_a = fe_a ? '0 : fa[0];
   endtask

   task automatic refresh_b();
      fe_b = (fb.size() == 0);
      fd_b = fe_b ? '0 : fb[0];
   endtask

   // Expected per-cycle line level and frame_done for one frame.
   task automatic push_frame(input bit to_b, input logic [31:0] w, input int width,
                             input int cpb, input logic par);
      logic bits[$];
      exp_t e;
      bits.push_back(1'b0);
      for (int i = 0; i < width; i++) bits.push_back(w[i]);
      bits.push_back(par);
      bits.push_back(1'b1);
      for (int k = 0; k < bits.size(); k++) begin
         for (int c = 0; c < cpb; c++) begin
            e.tx = bits[k];
            e.fd = (k == bits.size() - 1) && (c == cpb - 1);
            if (to_b) qb.push_back(e);
            else      qa.push_back(e);
         end
      end
   endtask

   // FIFO models: a pop strobe seen during a cycle retires the head just after the edge.
   always @(posedge clk) begin
      #1;
      if (pend_a) begin fa.delete(0); pops_a++; pend_a = 0; end
      if (pend_b) begin fb.delete(0); pops_b++; pend_b = 0; end
      refresh_a();
      refresh_b();
   end

   // Monitor / scoreboard.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (mon_en) begin
         if (rst_prev) begin
            chk("rst_tx_a", tx_a, 1);   chk("rst_busy_a", busy_a, 0); chk("rst_done_a", done_a, 0);
            chk("rst_tx_b", tx_b, 1);   chk("rst_busy_b", busy_b, 0); chk("rst_done_b", done_b, 0);
         end
         if (rst) begin
            chk("rst_deq_a", deq_a, 0); chk("rst_deq_b", deq_b, 0);
         end
         // DUT A
         if (busy_a && !sb_off_a) begin
            if (qa.size() == 0) begin
               checks++; failures++;
               $display("FAIL sb_a_unexpected_busy actual=1 required=0 at t=%0t", $time);
            end else begin
               e = qa.pop_front();
               chk("tx_a", tx_a, e.tx);
               chk("frame_done_a", done_a, e.fd);
            end
         end
         if (!busy_a) begin
            chk("idle_tx_a", tx_a, 1);
            chk("idle_done_a", done_a, 0);
         end
         if (done_a && !sb_off_a) chk("done_latency_a", cyc - last_pop_a, CA * (WA + 3));
         if (prev_deq_a && !rst_prev) begin
            chk("start_tx_a", tx_a, 0);
            chk("start_busy_a", busy_a, 1);
         end
         if (deq_a) begin
            chk("deq_nonempty_a", fe_a, 0);
            chk("deq_not_consec_a", prev_deq_a, 0);
            if (busy_a) chk("b2b_deq_with_done_a", done_a, 1);
            last_pop_a = cyc;
         end
         if (busy_a) busy_cnt_a++;
         // DUT B
         if (busy_b) begin
            if (qb.size() == 0) begin
               checks++; failures++;
               $display("FAIL sb_b_unexpected_busy actual=1 required=0 at t=%0t", $time);
            end else begin
               e = qb.pop_front();
               chk("tx_b", tx_b, e.tx);
               chk("frame_done_b", done_b, e.fd);
            end
         end
         if (!busy_b) chk("idle_tx_b", tx_b, 1);
         if (done_b) chk("done_latency_b", cyc - last_pop_b, CB * (WB + 3));
         if (prev_deq_b && !rst_prev) chk("start_tx_b", tx_b, 0);
         if (deq_b) begin
            chk("deq_nonempty_b", fe_b, 0);
            chk("deq_not_consec_b", prev_deq_b, 0);
            last_pop_b = cyc;
         end
         if (busy_b) busy_cnt_b++;
      end
      prev_deq_a = deq_a;
      prev_deq_b = deq_b;
      pend_a     = deq_a;
      pend_b     = deq_b;
      rst_prev   = rst;
   end

   task automatic wait_idle_a(input int limit);
      int n = 0;
      do begin @(negedge clk); n++; end while ((busy_a || deq_a) && n < limit);
      if (busy_a || deq_a) begin
         checks++; failures++;
         $display("FAIL timeout_idle_a actual=busy required=idle");
      end
   endtask

   task automatic wait_idle_b(input int limit);
      int n = 0;
      do begin @(negedge clk); n++; end while ((busy_b || deq_b) && n < limit);
      if (busy_b || deq_b) begin
         checks++; failures++;
         $display("FAIL timeout_idle_b actual=busy required=idle");
      end
   endtask

   initial begin
      int base;
      int n;
      // Reset with work pending: nothing may move until release.
      rst  = 1'b1;
      en_a = 1'b1;
      en_b = 1'b0;
      fa.push_back(8'hA5);
      fa.push_back(8'h01);
      refresh_a();
      refresh_b();
      push_frame(1'b0, 32'h0000_00A5, WA, CA, 1'b0);
      push_frame(1'b0, 32'h0000_0001, WA, CA, 1'b1);
      @(negedge clk);
      mon_en = 1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      busy_cnt_a = 0;
      @(negedge clk);
      chk("pop_first_cycle_after_rst", deq_a, 1);

      // Single frame 0xA5 followed back to back by 0x01.
      wait_idle_a(300);
      chk("b2b_busy_cycles", busy_cnt_a, 88);
      chk("fifo_a_drained", fa.size(), 0);
      chk("pops_after_b2b", pops_a, 2);

      // Enable gating with a non-empty FIFO.
      @(posedge clk);
      #2 en_a = 1'b0;
      fa.push_back(8'h3C);
      refresh_a();
      repeat (20) begin
         @(negedge clk);
         chk("gated_deq", deq_a, 0);
         chk("gated_tx", tx_a, 1);
      end
      push_frame(1'b0, 32'h0000_003C, WA, CA, 1'b0);
      busy_cnt_a = 0;
      base = pops_a;
      @(posedge clk);
      #2 en_a = 1'b1;
      repeat (10) @(posedge clk);
      #2 en_a = 1'b0;
      fa.push_back(8'h81);
      refresh_a();
      wait_idle_a(200);
      chk("en_drop_busy_cycles", busy_cnt_a, 44);
      chk("en_drop_pops", pops_a - base, 1);
      chk("en_drop_fifo_left", fa.size(), 1);
      fa.delete();
      refresh_a();

      // Reset in the middle of data bit 3.
      base = pops_a;
      sb_off_a = 1;
      @(posedge clk);
      #2;
      fa.push_back(8'h5A);
      refresh_a();
      en_a = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!deq_a && n < 50);
      chk("midrst_pop_seen", deq_a, 1);
      repeat (18) @(posedge clk);
      @(negedge clk);
      chk("midrst_bit3_tx", tx_a, 1);
      @(posedge clk);
      #2 rst = 1'b1;
      en_a = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("midrst_tx", tx_a, 1);
      chk("midrst_busy", busy_a, 0);
      chk("midrst_pops", pops_a - base, 1);
      chk("midrst_fifo_empty", fa.size(), 0);
      repeat (3) @(negedge clk);
      sb_off_a = 0;

      // CLKS_PER_BIT=1, WIDTH=32, all ones: 35-cycle frame, parity 0.
      fb.push_back(32'hFFFF_FFFF);
      refresh_b();
      push_frame(1'b1, 32'hFFFF_FFFF, WB, CB, 1'b0);
      busy_cnt_b = 0;
      @(posedge clk);
      #2 en_b = 1'b1;
      @(negedge clk);
      chk("pop_b", deq_b, 1);
      @(posedge clk);
      #2 en_b = 1'b0;
      wait_idle_b(100);
      chk("b_busy_cycles", busy_cnt_b, 35);
      @(negedge clk);
      chk("b_idle_high", tx_b, 1);

      chk("sb_a_empty", qa.size(), 0);
      chk("sb_b_empty", qb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fifo_serial_tx.md
# fifo_serial_tx

Read-side companion to the system-bus FIFO. It pops words from a FIFO's read port whenever one is available and enabled, and transmits each word as a framed bit-serial stream. The frame is a start bit, WIDTH data bits LSB first, an even-parity bit and a stop bit. It sits between a FIFO instance and an off-block serial link. It is the transmitter matching the FIFO's producer-side enqueue.

## Interface
- WIDTH, 32: data word width; must match the attached FIFO's WIDTH.
- CLKS_PER_BIT, 4: clock cycles per serial bit; must be ≥ 1.

- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset; one clock, sampled on rising edge of clk.
- en  input  1  transmit enable; gates only the start of a new frame.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  WIDTH  FIFO head word, first-word-fall-through (valid whenever fifo_empty=0).
- fifo_deq  output  1  one-cycle pop strobe to the FIFO.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is on the line (START..STOP).
- frame_done  output  1  one-cycle pulse on the last cycle of each STOP bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Every state other than IDLE lasts CLKS_PER_BIT cycles per bit.
- Counters:
  - baud counter: $clog2(CLKS_PER_BIT) bits, minimum 1 bit; counts 0..CLKS_PER_BIT-1.
  - bit index: $clog2(WIDTH) bits, counts 0..WIDTH-1 in DATA.
- Pop condition: en && !fifo_empty && (state==IDLE || last cycle of STOP).
  - fifo_deq is combinational from this condition.
  - In the same cycle, fifo_data is latched into a WIDTH-bit shift register.
  - Even parity is computed as XOR-reduce of fifo_data and latched.
  - State goes to START on the next edge.
- tx per state:
  - IDLE: 1.
  - START: 0.
  - DATA: shift_reg[0]; shift right by one at each bit boundary.
  - PARITY: latched parity.
  - STOP: 1.
- Transitions:
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → PARITY after WIDTH bits.
  - PARITY → STOP after CLKS_PER_BIT cycles.
  - STOP → START if the pop condition holds on its last cycle; otherwise STOP → IDLE.
- en deasserted mid-frame: the current frame completes; no new pop occurs.
- en=1 with fifo_empty=1: stay in IDLE, fifo_deq=0.
- fifo_deq must never assert while fifo_empty=1, and never in two consecutive cycles.

## Timing
- Reset values (cycle after rst=1): state IDLE, tx=1, busy=0, fifo_deq=0, frame_done=0, counters 0.
- Reset has priority over all activity.
- rst asserted mid-frame:
  - tx returns to 1 on the next cycle.
  - The latched word is discarded; it was already popped and is lost.
  - fifo_deq is forced to 0 during rst.
- Latency: pop at cycle N puts tx=0 at cycle N+1.
- Frame length: (WIDTH+3)*CLKS_PER_BIT cycles.
- busy rises at N+1 and falls after the last STOP cycle, unless the next frame follows back to back.
- Back-to-back frames: there is no idle cycle between the STOP of one frame and the START of the next. busy stays high and frame_done still pulses.
- CLKS_PER_BIT=1: each bit is exactly one cycle. The baud counter is always at its last count.
- Registered outputs: tx, busy, frame_done. Combinational output: fifo_deq.

## Test plan
- Reset: hold rst=1 for 3 cycles mid-IDLE and with fifo_empty=0, en=1 → tx=1, busy=0, fifo_deq=0 throughout; after release, pop occurs in the first cycle.
- Single frame (WIDTH=8, CLKS_PER_BIT=4), fifo_data=0xA5 → fifo_deq one cycle; tx holds each of the following for 4 cycles: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1 (44 cycles); frame_done pulses at cycle 44 after the pop.
- Back-to-back: FIFO holds 0xA5 then 0x01, en=1 → second fifo_deq coincides with frame_done of the first; second frame starts next cycle with no idle; 0x01 parity bit = 1; total 88 busy cycles.
- Enable gating: en=0 with FIFO non-empty for 20 cycles → no fifo_deq, tx=1. Then drop en mid-frame → frame finishes, no further pop.
- Reset mid-frame: assert rst during DATA bit 3 → next cycle tx=1, busy=0; FIFO read pointer advanced by exactly 1.
- CLKS_PER_BIT=1, WIDTH=32, fifo_data=0xFFFFFFFF → 35-cycle frame, parity 0, stop then idle high.
